mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL expose parameter AW, default 8, RAM word-address width.
REQ-002 SHALL expose parameter DW, default 16, RAM data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports p0_req/p1_req, input, 1 each, access request (p0 = CPU, p1 = loader/DMA).
REQ-006 SHALL have ports p0_cmd/p1_cmd, input, 2 each, 00 NONE, 01 READ, 10 WRITE, 11 treated as NONE.
REQ-007 SHALL have ports p0_addr/p1_addr, input, AW each, word address.
REQ-008 SHALL have ports p0_wdata/p1_wdata, input, DW each, write data.
REQ-009 SHALL have ports p0_done/p1_done, output, 1 each, one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, DW, registered read result, valid while the corresponding pX_done=1.
REQ-011 SHALL have port ram_cmd, output, 2, RAM command (same encoding as pX_cmd).
REQ-012 SHALL have port ram_addr, output, AW, RAM address.
REQ-013 SHALL have port ram_wdata, output, DW, RAM write data.
REQ-014 SHALL have port ram_rdata, input, DW, RAM read data, valid one cycle after ram_cmd=READ.
REQ-015 SHALL have port owner, output, 1, port currently granted (diagnostic).

Function
REQ-016 SHALL implement states IDLE, ACCESS, RESP.
REQ-017 IDLE: a port is eligible only if pX_req=1 and pX_cmd is READ or WRITE; otherwise it is ignored.
REQ-018 IDLE: with one eligible port, SHALL grant it; with both, SHALL grant the port indicated by the round-robin pointer rr.
REQ-019 On grant: latch owner, cmd, addr and wdata; go to ACCESS; rr SHALL point to the non-granted port.
REQ-020 ACCESS (exactly 1 cycle): ram_cmd/ram_addr/ram_wdata SHALL equal the latched values; in all other states ram_cmd SHALL be NONE; next state RESP.
REQ-021 RESP (exactly 1 cycle): the owner's pX_done=1; rdata SHALL hold ram_rdata captured at the ACCESS->RESP edge for READ and be unchanged for WRITE; next state IDLE.
REQ-022 Latency: request sampled at edge k -> ACCESS during cycle k+1 -> done during cycle k+2; back-to-back service, next grant sampled at edge k+3.
REQ-023 Requesters SHALL hold req/cmd/addr/wdata stable until done; a req still high in IDLE after done is a new request.
REQ-024 Input changes while ACCESS/RESP SHALL NOT affect the transaction in flight.
REQ-025 Starvation bound: a continuously asserted eligible request SHALL be granted within one other transaction.
REQ-026 p0_done and p1_done SHALL never be 1 in the same cycle.

Reset
REQ-027 On the clk edge with reset=1: state=IDLE, rr=p0, owner=0, rdata=0, latched cmd=NONE.
REQ-028 In the cycle after reset: ram_cmd=NONE and p0_done=p1_done=0, regardless of the interrupted state.
REQ-029 A transaction interrupted by reset SHALL be dropped without done; a WRITE already presented in ACCESS is not rolled back.

Structure
REQ-030 Memory command encodings NONE/READ/WRITE SHALL live in the shared constants include used by the CPU controller.
REQ-031 State encoding SHALL be local to mem_arbiter.
REQ-032 Grant selection SHALL be one sub-module, rr_pick2 (inputs: two eligibles plus rr; outputs: grant valid plus index); purely combinational.

Verification
REQ-033 Single READ: after reset, p0 READ addr 0x05 with RAM[5]=0x1234 -> ram_cmd=01 and addr 0x05 in cycle k+1; p0_done=1 and rdata=0x1234 in cycle k+2.
REQ-034 Single WRITE: p1 WRITE addr 0x10 data 0xBEEF -> ram_cmd=10 for exactly one cycle; p1_done one cycle later; readback of 0x10 returns 0xBEEF.
REQ-035 Contention: both ports request READ continuously from reset -> grants alternate p0,p1,p0,p1 with one done every 3 cycles; no cycle has both done.
REQ-036 Ineligible: p0_req=1 with cmd=11 -> no grant; ram_cmd stays 00 and no done for 10 cycles.
REQ-037 Reset mid-op: reset asserted during ACCESS of a p1 READ -> next cycle ram_cmd=00, no p1_done, rr=p0; a subsequent p1 request completes normally.
REQ-038 Stability: p0 changes addr during ACCESS -> RAM still sees the latched address; rdata matches the original address.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Memory command encodings shared by the arbiter and the CPU controller,
// plus a small helper that classifies a command as a real RAM access.
package mem_arbiter_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    // Only READ and WRITE reach the RAM; the reserved code behaves as NONE.
    function automatic logic cmd_is_access(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way grant picker: a lone eligible requester wins, a tie goes to the
// requester named by the round-robin pointer.
module rr_pick2 (
    input  logic elig0,
    input  logic elig1,
    input  logic rr,
    output logic gnt_valid,
    output logic gnt_idx
);

    // Combinational grant selection
    always_comb begin
        gnt_valid = elig0 | elig1;
        gnt_idx   = 1'b0;
        if (elig0 && elig1) begin
            gnt_idx = rr;
        end else if (elig1) begin
            gnt_idx = 1'b1;
        end else begin
            gnt_idx = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-RAM arbiter: IDLE -> ACCESS -> RESP per transaction, with
// round-robin fairness between the CPU (p0) and the loader/DMA (p1).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [1:0]    p0_cmd,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic [1:0]    p1_cmd,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_done,
    output logic          p1_done,
    output logic [DW-1:0] rdata,
    output logic [1:0]    ram_cmd,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    state_e        state_q,   state_d;
    logic          rr_q,      rr_d;
    logic          owner_q,   owner_d;
    logic [1:0]    cmd_q,     cmd_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic [1:0]    ram_cmd_q, ram_cmd_d;
    logic          p0_done_q, p0_done_d;
    logic          p1_done_q, p1_done_d;

    logic elig0_s, elig1_s, gnt_valid_s, gnt_idx_s;

    assign elig0_s = p0_req & cmd_is_access(p0_cmd);
    assign elig1_s = p1_req & cmd_is_access(p1_cmd);

    rr_pick2 u_pick (
        .elig0     (elig0_s),
        .elig1     (elig1_s),
        .rr        (rr_q),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Next-state, latch and output-register computation
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ram_cmd_d = CMD_NONE;
        p0_done_d = 1'b0;
        p1_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_d   = ST_ACCESS;
                    owner_d   = gnt_idx_s;
                    rr_d      = ~gnt_idx_s;
                    cmd_d     = gnt_idx_s ? p1_cmd   : p0_cmd;
                    addr_d    = gnt_idx_s ? p1_addr  : p0_addr;
                    wdata_d   = gnt_idx_s ? p1_wdata : p0_wdata;
                    // RAM command is registered so it appears exactly in ACCESS.
                    ram_cmd_d = gnt_idx_s ? p1_cmd   : p0_cmd;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (cmd_q == CMD_READ) begin
                    rdata_d = ram_rdata;
                end else begin
                    rdata_d = rdata_q;
                end
                p0_done_d = ~owner_q;
                p1_done_d = owner_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            owner_q   <= 1'b0;
            cmd_q     <= CMD_NONE;
            addr_q    <= {AW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            rdata_q   <= {DW{1'b0}};
            ram_cmd_q <= CMD_NONE;
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ram_cmd_q <= ram_cmd_d;
            p0_done_q <= p0_done_d;
            p1_done_q <= p1_done_d;
        end
    end

    assign p0_done   = p0_done_q;
    assign p1_done   = p1_done_q;
    assign rdata     = rdata_q;
    assign ram_cmd   = ram_cmd_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign owner     = owner_q;

endmodule
